// File: rtl/neuron_writeback.sv
`default_nettype none
// ============================================================================
// Module   : neuron_writeback
// Purpose  : Final MLP pipeline stage. Queues stage-4 neuron results in a
//            small write FIFO and commits them to the neuron memory write
//            port under a ready handshake. Counts committed writes and
//            raises layer_done once done_4 has been seen and the FIFO has
//            drained.
// Revision : 1.0 - initial release
//
// Ports:
//   clk               in   system clock (rising edge)
//   rst_n             in   asynchronous active-low reset
//   run               in   layer enable; low flushes everything synchronously
//   done_4            in   last neuron of the layer issued this cycle
//   out_4             in   neuron value (signed)
//   out_neuron_addr_4 in   neuron address
//   write_neuron_4    in   out_4 / out_neuron_addr_4 valid
//   mem_ready         in   memory accepts a write this cycle
//   mem_we            out  write request (FIFO non-empty)
//   mem_addr          out  FIFO head address
//   mem_wdata         out  FIFO head data
//   layer_done        out  layer fully committed
//   write_count       out  committed writes this layer (saturating)
//   overflow_err      out  sticky: a write was dropped on a full FIFO
//
// Build option:
//   NEURON_WB_RELU_EN  when defined, negative values are stored as zero.
// ============================================================================
module neuron_writeback #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              done_4,
    input  logic [DATA_W-1:0] out_4,
    input  logic [ADDR_W-1:0] out_neuron_addr_4,
    input  logic              write_neuron_4,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              layer_done,
    output logic [ADDR_W:0]   write_count,
    output logic              overflow_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [ADDR_W:0]   write_count_q;
    logic              overflow_q;
    logic              layer_done_q;

    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push_req;
    logic              w_push;
    logic              w_drop;
    logic [DATA_W-1:0] w_data_in;

    assign w_empty    = (count_q == '0);
    assign w_full     = (count_q == C_FULL);
    assign w_pop      = !w_empty && mem_ready;
    assign w_push_req = run && write_neuron_4;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

`ifdef NEURON_WB_RELU_EN
    assign w_data_in = out_4[DATA_W-1] ? '0 : out_4;
`else
    assign w_data_in = out_4;
`endif

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            write_count_q <= '0;
            overflow_q    <= 1'b0;
            layer_done_q  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else if (!run) begin
            // Flush: storage is cleared too so mem_addr/mem_wdata read 0.
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            write_count_q <= '0;
            overflow_q    <= 1'b0;
            layer_done_q  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (w_push) begin
                addr_q[wr_ptr_q] <= out_neuron_addr_4;
                data_q[wr_ptr_q] <= w_data_in;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                if (write_count_q != '1) begin
                    write_count_q <= write_count_q + 1'b1;
                end
            end
            if (w_drop) begin
                overflow_q <= 1'b1;
            end
            count_q <= count_d;

            case (state_q)
                S_IDLE:   state_q <= S_ACTIVE;
                S_ACTIVE: if (done_4) state_q <= S_DRAIN;
                S_DRAIN:  if (count_d == '0) state_q <= S_DONE;
                S_DONE:   if (w_push_req) state_q <= S_DRAIN;
                default:  state_q <= S_IDLE;
            endcase

            layer_done_q <= (state_q == S_DONE);
        end
    end

    assign mem_we       = !w_empty;
    assign mem_addr     = addr_q[rd_ptr_q];
    assign mem_wdata    = data_q[rd_ptr_q];
    assign layer_done   = layer_done_q;
    assign write_count  = write_count_q;
    assign overflow_err = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_neuron_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_neuron_writeback
// Purpose  : Self-checking bench for neuron_writeback: directed scenarios
//            plus randomized traffic checked against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_neuron_writeback;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              rst_n;
    logic              run;
    logic              done_4;
    logic [DATA_W-1:0] out_4;
    logic [ADDR_W-1:0] out_neuron_addr_4;
    logic              write_neuron_4;
    logic              mem_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              layer_done;
    logic [ADDR_W:0]   write_count;
    logic              overflow_err;

    int checks   = 0;
    int failures = 0;

    neuron_writeback #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .done_4(done_4),
        .out_4(out_4), .out_neuron_addr_4(out_neuron_addr_4),
        .write_neuron_4(write_neuron_4), .mem_ready(mem_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .layer_done(layer_done), .write_count(write_count),
        .overflow_err(overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] stored(input logic [DATA_W-1:0] v);
`ifdef NEURON_WB_RELU_EN
        return ($signed(v) < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Advance one clock edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        run = 1'b0; write_neuron_4 = 1'b0; done_4 = 1'b0; mem_ready = 1'b0;
        tick();
        run = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; done_4 = 1'b0; write_neuron_4 = 1'b0;
        mem_ready = 1'b0; out_4 = '0; out_neuron_addr_4 = '0;
        tick(); tick();
        rst_n = 1'b1;
        run = 1'b1; write_neuron_4 = 1'b1; out_neuron_addr_4 = 12'h03A; out_4 = 16'h0055;
        tick();
        write_neuron_4 = 1'b0;
        tick();
        checks++;
        if (mem_we !== 1'b1) begin
            failures++; $display("FAIL pre_reset_we got=%0b exp=1", mem_we);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_we, mem_addr, mem_wdata, layer_done, write_count, overflow_err} !== '0) begin
            failures++;
            $display("FAIL async_reset we=%0b addr=%h data=%h done=%0b cnt=%0d ovf=%0b exp all 0",
                     mem_we, mem_addr, mem_wdata, layer_done, write_count, overflow_err);
        end
        tick();
        rst_n = 1'b1; run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            write_neuron_4 = 1'b1; out_neuron_addr_4 = 12'(i);
            tick();
            write_neuron_4 = 1'b0;
            checks++;
            if (mem_we !== 1'b0 || write_count !== '0) begin
                failures++;
                $display("FAIL idle_ignore cyc=%0d we=%0b cnt=%0d exp we=0 cnt=0", i, mem_we, write_count);
            end
        end
    endtask

    task automatic test_single_write();
        flush();
        mem_ready = 1'b1; write_neuron_4 = 1'b1;
        out_neuron_addr_4 = 12'h005; out_4 = 16'h1234;
        tick();
        write_neuron_4 = 1'b0;
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 12'h005 || mem_wdata !== 16'h1234) begin
            failures++;
            $display("FAIL single_head we=%0b addr=%h data=%h exp 1/005/1234", mem_we, mem_addr, mem_wdata);
        end
        tick();
        checks++;
        if (mem_we !== 1'b0 || write_count !== 13'd1) begin
            failures++;
            $display("FAIL single_commit we=%0b cnt=%0d exp we=0 cnt=1", mem_we, write_count);
        end
    endtask

    task automatic test_overflow();
        flush();
        for (int i = 0; i < 5; i++) begin
            write_neuron_4 = 1'b1; out_neuron_addr_4 = 12'(i); out_4 = 16'h0100 + 16'(i);
            tick();
            if (i == 3) begin
                checks++;
                if (overflow_err !== 1'b0) begin
                    failures++; $display("FAIL ovf_at_full got=%0b exp=0", overflow_err);
                end
            end
        end
        write_neuron_4 = 1'b0;
        checks++;
        if (overflow_err !== 1'b1) begin
            failures++; $display("FAIL ovf_set got=%0b exp=1", overflow_err);
        end
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== 12'(i) || mem_wdata !== 16'h0100 + 16'(i)) begin
                failures++;
                $display("FAIL ovf_order idx=%0d we=%0b addr=%h data=%h exp addr=%h data=%h",
                         i, mem_we, mem_addr, mem_wdata, 12'(i), 16'h0100 + 16'(i));
            end
            tick();
        end
        checks++;
        if (mem_we !== 1'b0 || write_count !== 13'd4 || overflow_err !== 1'b1) begin
            failures++;
            $display("FAIL ovf_drain we=%0b cnt=%0d ovf=%0b exp 0/4/1", mem_we, write_count, overflow_err);
        end
    endtask

    task automatic test_done_pending();
        flush();
        for (int i = 0; i < 3; i++) begin
            write_neuron_4 = 1'b1; out_neuron_addr_4 = 12'(10 + i); out_4 = 16'(i + 1);
            tick();
        end
        write_neuron_4 = 1'b0; done_4 = 1'b1;
        tick();
        done_4 = 1'b0;
        tick(); tick();
        checks++;
        if (layer_done !== 1'b0 || mem_we !== 1'b1) begin
            failures++;
            $display("FAIL done_pending done=%0b we=%0b exp done=0 we=1", layer_done, mem_we);
        end
        mem_ready = 1'b1;
        tick(); tick(); tick();
        tick();
        checks++;
        if (layer_done !== 1'b1 || write_count !== 13'd3 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL done_after_drain done=%0b cnt=%0d we=%0b exp 1/3/0", layer_done, write_count, mem_we);
        end
        // A late write re-opens the layer.
        mem_ready = 1'b0; write_neuron_4 = 1'b1; out_neuron_addr_4 = 12'h077;
        tick();
        write_neuron_4 = 1'b0;
        tick();
        checks++;
        if (layer_done !== 1'b0 || mem_we !== 1'b1) begin
            failures++;
            $display("FAIL done_reopen done=%0b we=%0b exp done=0 we=1", layer_done, mem_we);
        end
    endtask

    task automatic test_relu();
        flush();
        write_neuron_4 = 1'b1; out_neuron_addr_4 = 12'h001; out_4 = 16'h8001;
        tick();
        out_neuron_addr_4 = 12'h002; out_4 = 16'h7FFF;
        tick();
        write_neuron_4 = 1'b0;
        checks++;
        if (mem_wdata !== stored(16'h8001)) begin
            failures++; $display("FAIL relu_neg got=%h exp=%h", mem_wdata, stored(16'h8001));
        end
        mem_ready = 1'b1;
        tick();
        checks++;
        if (mem_wdata !== 16'h7FFF || mem_addr !== 12'h002) begin
            failures++; $display("FAIL relu_pos data=%h addr=%h exp 7fff/002", mem_wdata, mem_addr);
        end
    endtask

    task automatic test_flush();
        flush();
        for (int i = 0; i < 5; i++) begin
            write_neuron_4 = 1'b1; out_neuron_addr_4 = 12'h200 + 12'(i); out_4 = 16'h0A00 + 16'(i);
            done_4 = (i == 4);
            tick();
        end
        write_neuron_4 = 1'b0; done_4 = 1'b0; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        checks++;
        if (write_count !== 13'd1 || overflow_err !== 1'b1 || mem_we !== 1'b1) begin
            failures++;
            $display("FAIL flush_setup cnt=%0d ovf=%0b we=%0b exp 1/1/1", write_count, overflow_err, mem_we);
        end
        run = 1'b0;
        tick();
        checks++;
        if ({mem_we, mem_addr, mem_wdata, layer_done, write_count, overflow_err} !== '0) begin
            failures++;
            $display("FAIL flush_clear we=%0b addr=%h data=%h done=%0b cnt=%0d ovf=%0b exp all 0",
                     mem_we, mem_addr, mem_wdata, layer_done, write_count, overflow_err);
        end
        run = 1'b1;
        tick();
        checks++;
        if (mem_we !== 1'b0 || layer_done !== 1'b0) begin
            failures++; $display("FAIL flush_restart we=%0b done=%0b exp 0/0", mem_we, layer_done);
        end
    endtask

    // Randomized traffic vs. a queue model of the FIFO, counter and sticky flag.
    task automatic test_random();
        logic [ADDR_W-1:0] qa[$];
        logic [DATA_W-1:0] qd[$];
        int unsigned       m_cnt;
        logic              m_ovf;
        logic              pop;
        flush();
        m_cnt = 0; m_ovf = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            run               = ($urandom_range(0, 39) != 0);
            write_neuron_4    = ($urandom_range(0, 9) < 6);
            mem_ready         = ($urandom_range(0, 9) < 5);
            out_neuron_addr_4 = 12'($urandom);
            out_4             = 16'($urandom);
            if (!run) begin
                qa.delete(); qd.delete(); m_cnt = 0; m_ovf = 1'b0;
            end else begin
                pop = (qa.size() > 0) && mem_ready;
                if (pop) begin
                    void'(qa.pop_front()); void'(qd.pop_front());
                    if (m_cnt < (1 << (ADDR_W + 1)) - 1) m_cnt++;
                end
                if (write_neuron_4) begin
                    if (qa.size() < DEPTH) begin
                        qa.push_back(out_neuron_addr_4);
                        qd.push_back(stored(out_4));
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
            tick();
            checks++;
            if (mem_we !== (qa.size() > 0) || write_count !== 13'(m_cnt) || overflow_err !== m_ovf) begin
                failures++;
                $display("FAIL rand_status cyc=%0d we=%0b cnt=%0d ovf=%0b exp we=%0b cnt=%0d ovf=%0b",
                         cyc, mem_we, write_count, overflow_err, qa.size() > 0, m_cnt, m_ovf);
            end
            if (qa.size() > 0) begin
                checks++;
                if (mem_addr !== qa[0] || mem_wdata !== qd[0]) begin
                    failures++;
                    $display("FAIL rand_head cyc=%0d addr=%h data=%h exp addr=%h data=%h",
                             cyc, mem_addr, mem_wdata, qa[0], qd[0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_overflow();
        test_done_pending();
        test_relu();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
